// File: rtl/spram_fifo_ctrl.sv
// Streaming FIFO controller that drives a single-port registered-address RAM,
// alternating reads and writes on the one port and buffering read data in a 2-entry output stage.
module spram_fifo_ctrl #(
    parameter int addr_width = 6,
    parameter int data_width = 8,
    parameter int depth      = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [data_width-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [data_width-1:0]   out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [addr_width+1:0]   level,
    output logic [data_width-1:0]   ram_data,
    output logic [addr_width-1:0]   ram_addr,
    output logic                    ram_we,
    input  logic [data_width-1:0]   ram_q
);

    localparam logic [addr_width:0] full_cnt = (addr_width+1)'(depth);

    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   ram_cnt;
    logic                  rd_pend;
    logic [1:0]            out_cnt;
    logic [data_width-1:0] ob_head;
    logic [data_width-1:0] ob_tail;

    logic rd_issue;
    logic wr_fire;
    logic pop;
    logic cap_head;

    always_comb begin
        // A read is only issued when its returning word is guaranteed a buffer slot.
        rd_issue  = (ram_cnt != '0) && ((out_cnt + {1'b0, rd_pend}) < 2'd2);
        in_ready  = rst_n && !rd_issue && (ram_cnt != full_cnt);
        wr_fire   = in_valid && in_ready;
        ram_we    = wr_fire;
        ram_addr  = rd_issue ? rd_ptr : wr_ptr;
        ram_data  = in_data;
        out_valid = (out_cnt != 2'd0);
        out_data  = ob_head;
        pop       = out_valid && out_ready;
        // Captured word lands in the head slot whenever the buffer is empty after this edge's pop.
        cap_head  = (out_cnt == 2'd0) || ((out_cnt == 2'd1) && pop);
        level     = {1'b0, ram_cnt} + (addr_width+2)'(rd_pend) + (addr_width+2)'(out_cnt);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            rd_pend <= 1'b0;
            out_cnt <= 2'd0;
        end else begin
            if (rd_issue) begin
                rd_ptr  <= rd_ptr + addr_width'(1);
                ram_cnt <= ram_cnt - (addr_width+1)'(1);
            end else if (wr_fire) begin
                wr_ptr  <= wr_ptr + addr_width'(1);
                ram_cnt <= ram_cnt + (addr_width+1)'(1);
            end
            rd_pend <= rd_issue;
            out_cnt <= out_cnt + {1'b0, rd_pend} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ob_head <= '0;
            ob_tail <= '0;
        end else begin
            if (pop) begin
                ob_head <= ob_tail;
            end
            // NOTE: when pop and capture both target ob_head, the later assignment (the capture) wins.
            if (rd_pend) begin
                if (cap_head) begin
                    ob_head <= ram_q;
                end else begin
                    ob_tail <= ram_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Self-checking bench for spram_fifo_ctrl: a behavioural RAM on the port side and
// a queue holding every accepted-but-not-yet-popped word as the reference FIFO.
module tb_spram_fifo_ctrl;

    localparam int addr_width = 6;
    localparam int data_width = 8;
    localparam int depth      = 64;

    logic                  clk;
    logic                  rst_n;
    logic [data_width-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [addr_width+1:0] level;
    logic [data_width-1:0] ram_data;
    logic [addr_width-1:0] ram_addr;
    logic                  ram_we;
    logic [data_width-1:0] ram_q;

    spram_fifo_ctrl #(.addr_width(addr_width), .data_width(data_width), .depth(depth)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: write when we=1, otherwise registered-address read.
    logic [data_width-1:0] mem [depth];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        else        ram_q <= mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;
    logic [data_width-1:0] model_q [$];

    // Per-cycle handshake observations filled in by tick().
    bit                    t_acc;
    bit                    t_pop;
    bit                    t_we;
    logic [data_width-1:0] t_got;
    logic [data_width-1:0] t_exp;

    task automatic tick();
        #1;
        t_acc = in_valid && in_ready;
        t_pop = out_valid && out_ready;
        t_we  = ram_we;
        t_got = out_data;
        t_exp = '0;
        if (t_pop) begin
            if (model_q.size() > 0) t_exp = model_q.pop_front();
            else                    t_exp = ~t_got;
        end
        if (t_acc) model_q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 1'b1;
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h exp 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        checks++; if (level !== '0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0h exp 0", in_ready); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we got %0h exp 0", ram_we); end
        checks++; if (ram_addr !== '0) begin errors++; $display("FAIL reset_ram_addr got %0h exp 0", ram_addr); end
        checks++; if (ram_data !== 8'h5A) begin errors++; $display("FAIL reset_ram_data got %0h exp 5a", ram_data); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0 || level !== '0) begin
            errors++; $display("FAIL reset_held in_ready %0h level %0d exp 0 0", in_ready, level);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        model_q.delete();
    endtask

    task automatic test_basic_latency();
        logic [data_width-1:0] vals [3];
        int idx = 0;
        int t_first = -1;
        int t_valid = -1;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        apply_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? vals[idx] : 8'h00;
            tick();
            if (t_acc) begin
                if (idx == 0) t_first = cyc;
                idx++;
            end
            if (out_valid && t_valid < 0) t_valid = cyc;
        end
        in_valid = 1'b0;
        checks++; if (idx != 3) begin errors++; $display("FAIL basic_accept_count got %0d exp 3", idx); end
        checks++; if (t_valid - t_first != 2) begin
            errors++; $display("FAIL basic_latency got %0d exp 2 edges after accept", t_valid - t_first);
        end
        checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL basic_head got %0h exp 11", out_data); end
        checks++; if (level !== 8'd3) begin errors++; $display("FAIL basic_level got %0d exp 3", level); end
        checks++; if (dut.ram_cnt !== 7'd1) begin errors++; $display("FAIL basic_ram_cnt got %0d exp 1", dut.ram_cnt); end
        checks++; if (dut.out_cnt !== 2'd2) begin errors++; $display("FAIL basic_out_cnt got %0d exp 2", dut.out_cnt); end
    endtask

    task automatic test_fill_drain();
        int n = 0;
        int k = 0;
        apply_reset();
        for (int cyc = 0; cyc < 400 && n < depth + 2; cyc++) begin
            in_valid = 1'b1;
            in_data  = 8'(n);
            tick();
            if (t_acc) n++;
        end
        checks++; if (n != depth + 2) begin errors++; $display("FAIL fill_count got %0d exp %0d", n, depth + 2); end
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got %0h exp 0", in_ready); end
        checks++; if (level !== 8'(depth + 2)) begin errors++; $display("FAIL fill_level got %0d exp %0d", level, depth + 2); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (t_acc) begin errors++; $display("FAIL fill_ignored got accept exp none"); end
        end
        checks++; if (level !== 8'(depth + 2)) begin errors++; $display("FAIL fill_level_hold got %0d exp %0d", level, depth + 2); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && model_q.size() > 0; cyc++) begin
            tick();
            if (t_pop) begin
                checks++; if (t_got !== t_exp || t_got !== 8'(k)) begin
                    errors++; $display("FAIL drain_data got %0h exp %0h", t_got, t_exp);
                end
                k++;
            end
        end
        out_ready = 1'b0;
        checks++; if (k != depth + 2) begin errors++; $display("FAIL drain_count got %0d exp %0d", k, depth + 2); end
        checks++; if (level !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_empty level %0d out_valid %0h exp 0 0", level, out_valid);
        end
    endtask

    task automatic test_stream();
        int next = 0;
        int pops = 0;
        apply_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            in_data = 8'(next);
            tick();
            if (t_acc) next++;
            checks++; if (t_we !== t_acc) begin errors++; $display("FAIL stream_ram_we got %0h exp %0h", t_we, t_acc); end
            if (t_pop) begin
                pops++;
                checks++; if (t_got !== t_exp) begin errors++; $display("FAIL stream_data got %0h exp %0h", t_got, t_exp); end
            end
            checks++; if (level !== 8'(model_q.size())) begin
                errors++; $display("FAIL stream_level got %0d exp %0d", level, model_q.size());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (pops < 90) begin errors++; $display("FAIL stream_throughput got %0d exp >=90", pops); end
    endtask

    task automatic test_wrap_random();
        int sent = 0;
        int recv = 0;
        apply_reset();
        for (int cyc = 0; cyc < 3000 && recv < 150; cyc++) begin
            in_valid  = (sent < 150) && ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            tick();
            if (t_acc) sent++;
            if (t_pop) begin
                recv++;
                checks++; if (t_got !== t_exp) begin errors++; $display("FAIL wrap_data got %0h exp %0h", t_got, t_exp); end
            end
            checks++; if (level !== 8'(model_q.size())) begin
                errors++; $display("FAIL wrap_level got %0d exp %0d", level, model_q.size());
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (recv != 150) begin errors++; $display("FAIL wrap_count got %0d exp 150", recv); end
    endtask

    // Writes n words with the output stalled, then lets the RAM side settle.
    task automatic preload(input int n);
        int cnt = 0;
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 100 && cnt < n; cyc++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            tick();
            if (t_acc) cnt++;
        end
        in_valid = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_pop_capture();
        apply_reset();
        preload(4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++; if (level !== 8'd3) begin errors++; $display("FAIL popcap_pre_level got %0d exp 3", level); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (!t_pop || t_got !== t_exp) begin
            errors++; $display("FAIL popcap_pop got %0h exp %0h", t_got, t_exp);
        end
        checks++; if (dut.out_cnt !== 2'd1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL popcap_out_cnt got %0d exp 1", dut.out_cnt);
        end
        checks++; if (out_data !== model_q[0]) begin
            errors++; $display("FAIL popcap_head got %0h exp %0h", out_data, model_q[0]);
        end
        checks++; if (level !== 8'd2) begin errors++; $display("FAIL popcap_level got %0d exp 2", level); end
    endtask

    task automatic test_reset_mid_read();
        bit first_seen = 1'b0;
        apply_reset();
        preload(6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        checks++; if (level !== 8'd5) begin errors++; $display("FAIL midrst_pre_level got %0d exp 5", level); end
        rst_n = 1'b0;
        model_q.delete();
        #1;
        checks++; if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs out_valid %0h level %0d in_ready %0h exp 0 0 0",
                               out_valid, level, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 8'hA5 : 8'(8'h50 + i);
            for (int cyc = 0; cyc < 10; cyc++) begin
                tick();
                if (t_acc) break;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 50 && model_q.size() > 0; cyc++) begin
            tick();
            if (t_pop) begin
                checks++; if (t_got !== t_exp) begin errors++; $display("FAIL midrst_data got %0h exp %0h", t_got, t_exp); end
                if (!first_seen) begin
                    first_seen = 1'b1;
                    checks++; if (t_got !== 8'hA5) begin errors++; $display("FAIL midrst_first got %0h exp a5", t_got); end
                end
            end
        end
        out_ready = 1'b0;
        checks++; if (!first_seen || model_q.size() != 0) begin
            errors++; $display("FAIL midrst_drain left %0d exp 0", model_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_fill_drain();
        test_stream();
        test_wrap_random();
        test_pop_capture();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
